// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, shift-select bit positions,
// lock FSM states and the illegal-combination rule.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_OR    = 3'b010;
  localparam logic [2:0] OP_LUI   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_NOR   = 3'b110;
  localparam logic [2:0] OP_SHIFT = 3'b111;

  localparam int SH_SLL  = 0;
  localparam int SH_SRL  = 1;
  localparam int SH_SRA  = 2;
  localparam int SH_SLLV = 3;
  localparam int SH_SRLV = 4;
  localparam int SH_SRAV = 5;

  typedef enum logic {ARB, LOCKED} arb_state_e;

  // More than one shift flag is never meaningful; a shift op must name exactly one.
  function automatic logic is_illegal(input logic [2:0] ctrl, input logic [5:0] shsel);
    return ($countones(shsel) > 1) || (ctrl == OP_SHIFT && shsel == 6'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester at or after the pointer that is
// both requesting and allowed by the eligibility mask; the pointer moves past each winner.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] cand;
  logic [PW:0]     pos;

  assign cand = req & mask;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  // Scan from the farthest offset back to the pointer so the nearest candidate wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    pos       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
      if (cand[pos[PW-1:0]]) begin
        grant              = '0;
        grant[pos[PW-1:0]] = 1'b1;
        grant_idx          = pos[PW-1:0];
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= '0;
    else if (|grant) ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-result ALU among NREQ requesters: round-robin grant with
// optional lock, flag realignment to the result cycle, one-hot tagged response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [3*NREQ-1:0]  req_ctrl,
  input  logic [6*NREQ-1:0]  req_shsel,
  input  logic [5*NREQ-1:0]  req_shamt,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [2:0]         alu_ctrl,
  output logic [5:0]         alu_shsel,
  output logic [4:0]         alu_s,
  input  logic [31:0]        alu_result,
  input  logic               alu_zero,
  input  logic [31:0]        alu_sign,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_result,
  output logic               rsp_zero,
  output logic               rsp_neg,
  output logic               rsp_err
);

  localparam int PW = $clog2(NREQ);

  arb_state_e      state;
  logic [PW-1:0]   owner;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win;
  logic            accept;
  logic            illegal;
  logic [2:0]      sel_ctrl;
  logic [5:0]      sel_shsel;
  logic [4:0]      sel_shamt;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            sel_lock;
  logic            zero_q;
  logic            neg_q;
  logic            err_q;
  logic            unused_sign;

  // Only bit 0 of the sign word carries information.
  assign unused_sign = ^alu_sign[31:1];

  assign eligible = (state == LOCKED) ? (NREQ'(1) << owner) : '1;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid & ~{NREQ{rst}}),
    .mask      (eligible),
    .grant     (grant),
    .grant_idx (win)
  );

  assign accept    = |grant;
  assign req_ready = grant;

  // One-hot grant selects the winner's fields; an idle cycle leaves the ALU bus at 0.
  always_comb begin
    sel_ctrl  = '0;
    sel_shsel = '0;
    sel_shamt = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_lock  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_ctrl  = req_ctrl[i*3 +: 3];
        sel_shsel = req_shsel[i*6 +: 6];
        sel_shamt = req_shamt[i*5 +: 5];
        sel_a     = req_a[i*32 +: 32];
        sel_b     = req_b[i*32 +: 32];
        sel_lock  = req_lock[i];
      end
    end
  end

  assign illegal   = accept && is_illegal(sel_ctrl, sel_shsel);
  assign alu_a     = sel_a;
  assign alu_b     = sel_b;
  assign alu_ctrl  = sel_ctrl;
  assign alu_s     = sel_shamt;
  assign alu_shsel = (sel_ctrl == OP_SHIFT && !illegal) ? sel_shsel : 6'd0;

  // Flags are combinational at the ALU, so they are captured here to line up with
  // the result the ALU registers on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      owner     <= '0;
      rsp_valid <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rsp_valid <= grant;
      zero_q    <= accept & alu_zero;
      neg_q     <= accept & alu_sign[0];
      err_q     <= illegal;
      if (accept) begin
        if (state == ARB && sel_lock) begin
          state <= LOCKED;
          owner <= win;
        end else if (state == LOCKED && !sel_lock) begin
          state <= ARB;
        end
      end
    end
  end

  assign rsp_zero   = zero_q;
  assign rsp_neg    = neg_q;
  assign rsp_err    = err_q;
  assign rsp_result = (err_q || rsp_valid == '0) ? 32'd0 : alu_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with a behavioural ALU attached; a
// reference arbiter predicts grants and responses, a monitor retires them.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int  N      = 2;
  localparam time PERIOD = 10;

  typedef struct {
    logic [2:0]  ctrl;
    logic [5:0]  shsel;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        lock;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        err;
    time         t;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_ready, req_lock;
  logic [3*N-1:0]  req_ctrl;
  logic [6*N-1:0]  req_shsel;
  logic [5*N-1:0]  req_shamt;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     alu_a, alu_b, alu_result, alu_sign, alu_comb, rsp_result;
  logic [2:0]      alu_ctrl;
  logic [5:0]      alu_shsel;
  logic [4:0]      alu_s;
  logic            alu_zero, rsp_zero, rsp_neg, rsp_err;
  logic [N-1:0]    rsp_valid;

  op_t  rq[N][$];
  exp_t sb[$];
  int   last_win   = N - 1;
  int   lock_owner = -1;
  int   n_cmp      = 0;
  int   n_fail     = 0;
  exp_t mon_e;
  logic [N-1:0] mon_ev;

  alu_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_ctrl(req_ctrl), .req_shsel(req_shsel), .req_shamt(req_shamt),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_shsel(alu_shsel), .alu_s(alu_s),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_neg(rsp_neg), .rsp_err(rsp_err)
  );

  always #(PERIOD/2) clk = ~clk;

  // MIPS-style ALU behaviour, used both as the attached ALU and as the reference.
  function automatic logic [31:0] alu_fn(logic [2:0] c, logic [5:0] sh, logic [4:0] s,
                                         logic [31:0] a, logic [31:0] b);
    case (c)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_OR:  return a | b;
      OP_LUI: return {b[15:0], 16'h0000};
      OP_AND: return a & b;
      OP_XOR: return a ^ b;
      OP_NOR: return ~(a | b);
      default: begin
        if (sh[SH_SLL])  return b << s;
        if (sh[SH_SRL])  return b >> s;
        if (sh[SH_SRA])  return $signed(b) >>> s;
        if (sh[SH_SLLV]) return b << a[4:0];
        if (sh[SH_SRLV]) return b >> a[4:0];
        if (sh[SH_SRAV]) return $signed(b) >>> a[4:0];
        return 32'd0;
      end
    endcase
  endfunction

  always_comb alu_comb = alu_fn(alu_ctrl, alu_shsel, alu_s, alu_a, alu_b);
  assign alu_zero = (alu_comb == 32'd0);
  assign alu_sign = {31'd0, alu_comb[31]};
  always @(posedge clk) alu_result <= alu_comb;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(logic [2:0] c, logic [5:0] sh, logic [4:0] s,
                             logic [31:0] a, logic [31:0] b, logic lk);
    op_t o;
    o.ctrl = c; o.shsel = sh; o.shamt = s; o.a = a; o.b = b; o.lock = lk;
    return o;
  endfunction

  function automatic op_t rand_op();
    int k, b1, b2;
    op_t o;
    o.ctrl = 3'($urandom_range(0, 7));
    k  = $urandom_range(0, 3);
    b1 = $urandom_range(0, 5);
    b2 = (b1 + $urandom_range(1, 5)) % 6;
    o.shsel = (k == 0) ? 6'd0 : (k == 3) ? ((6'd1 << b1) | (6'd1 << b2)) : (6'd1 << b1);
    o.shamt = 5'($urandom);
    o.a     = $urandom;
    o.b     = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
    o.lock  = ($urandom_range(0, 4) == 0);
    return o;
  endfunction

  // Bad op: two or more shift flags, or a shift op naming none.
  function automatic logic illegal_ref(op_t o);
    int flags = 0;
    for (int j = 0; j < 6; j++) flags += int'(o.shsel[j]);
    return (flags > 1) || (o.ctrl == OP_SHIFT && flags == 0);
  endfunction

  function automatic int predict_winner();
    int i;
    if (lock_owner >= 0) return (rq[lock_owner].size() > 0) ? lock_owner : -1;
    for (int k = 1; k <= N; k++) begin
      i = (last_win + k) % N;
      if (rq[i].size() > 0) return i;
    end
    return -1;
  endfunction

  function automatic logic pending();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    op_t o;
    req_valid = '0; req_lock = '0; req_ctrl = '0; req_shsel = '0;
    req_shamt = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        o = rq[i][0];
        req_valid[i]         = 1'b1;
        req_lock[i]          = o.lock;
        req_ctrl[i*3 +: 3]   = o.ctrl;
        req_shsel[i*6 +: 6]  = o.shsel;
        req_shamt[i*5 +: 5]  = o.shamt;
        req_a[i*32 +: 32]    = o.a;
        req_b[i*32 +: 32]    = o.b;
      end
    end
  endtask

  // One clock: present queue heads, predict and check the grant, enqueue the expected response.
  task automatic step();
    int          w;
    op_t         o;
    exp_t        e;
    logic [N-1:0] exp_ready;
    logic [5:0]  sh_eff;
    logic [31:0] r;
    drive();
    @(negedge clk);
    w = predict_winner();
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (w >= 0) begin
      o      = rq[w].pop_front();
      e.err  = illegal_ref(o);
      sh_eff = (o.ctrl == OP_SHIFT && !e.err) ? o.shsel : 6'd0;
      check("alu_shsel", 32'(alu_shsel), 32'(sh_eff));
      check("alu_ctrl_s", {24'd0, alu_ctrl, alu_s}, {24'd0, o.ctrl, o.shamt});
      check("alu_a", alu_a, o.a);
      check("alu_b", alu_b, o.b);
      r        = alu_fn(o.ctrl, sh_eff, o.shamt, o.a, o.b);
      e.id     = w;
      e.result = e.err ? 32'd0 : r;
      e.zero   = (r == 32'd0);
      e.neg    = r[31];
      e.t      = $time;
      sb.push_back(e);
      if (lock_owner < 0 && o.lock) lock_owner = w;
      else if (lock_owner >= 0 && !o.lock) lock_owner = -1;
      last_win = w;
    end else begin
      check("idle_alu_bus", alu_a | alu_b | {24'd0, alu_ctrl, alu_s}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 200;
    while (pending() && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: requests still queued after 200 cycles");
    end
    step();
    step();
  endtask

  task automatic reset_model();
    sb.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    last_win   = N - 1;
    lock_owner = -1;
  endtask

  // Response monitor: every presented response must match the oldest expectation, one cycle late.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e  = sb.pop_front();
          mon_ev = '0;
          mon_ev[mon_e.id] = 1'b1;
          check("rsp_latency", 32'($time - mon_e.t), 32'(PERIOD));
          check("rsp_valid", 32'(rsp_valid), 32'(mon_ev));
          check("rsp_result", rsp_result, mon_e.result);
          check("rsp_flags", {29'd0, rsp_zero, rsp_neg, rsp_err},
                {29'd0, mon_e.zero, mon_e.neg, mon_e.err});
        end
      end else if (sb.size() > 0 && sb[0].t < $time) begin
        mon_e = sb.pop_front();
        check("rsp_missing", 32'(rsp_valid), 32'(1) << mon_e.id);
      end
    end
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_flags", {29'd0, rsp_zero, rsp_neg, rsp_err}, 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    rq[0].push_back(mk(OP_ADD, 6'd0, 5'd0, 32'd5, 32'd7, 1'b0));
    drain();

    for (int k = 0; k < 2; k++) begin
      rq[0].push_back(mk(OP_SUB, 6'd0, 5'd0, 32'd3, 32'd3, 1'b0));
      rq[1].push_back(mk(OP_OR, 6'd0, 5'd0, 32'hF0, 32'h0F, 1'b0));
    end
    drain();

    rq[1].push_back(mk(OP_SUB, 6'd0, 5'd0, 32'd1, 32'd2, 1'b0));
    rq[1].push_back(mk(OP_LUI, 6'd0, 5'd0, 32'd0, 32'h1234, 1'b0));
    drain();

    for (int k = 0; k < 3; k++) rq[0].push_back(mk(OP_ADD, 6'd0, 5'd0, k, 32'd1, 1'b1));
    rq[0].push_back(mk(OP_XOR, 6'd0, 5'd0, 32'hAA, 32'h55, 1'b0));
    rq[0].push_back(mk(OP_AND, 6'd0, 5'd0, 32'hFF, 32'h0F, 1'b0));
    for (int k = 0; k < 2; k++) rq[1].push_back(mk(OP_NOR, 6'd0, 5'd0, 32'd0, k, 1'b0));
    drain();

    rq[0].push_back(mk(OP_SHIFT, 6'd1 << SH_SRA, 5'd4, 32'd0, 32'h8000_0000, 1'b0));
    rq[0].push_back(mk(OP_SHIFT, (6'd1 << SH_SLL) | (6'd1 << SH_SRL), 5'd3, 32'd0, 32'h1, 1'b0));
    rq[1].push_back(mk(OP_SHIFT, 6'd0, 5'd1, 32'd9, 32'd9, 1'b0));
    rq[1].push_back(mk(OP_ADD, 6'd1 << SH_SLLV, 5'd1, 32'd2, 32'd2, 1'b0));
    drain();

    rq[0].push_back(mk(OP_ADD, 6'd0, 5'd0, 32'd9, 32'd9, 1'b0));
    step();
    rst = 1'b1;
    reset_model();
    rq[0].push_back(mk(OP_ADD, 6'd0, 5'd0, 32'd1, 32'd1, 1'b0));
    rq[1].push_back(mk(OP_SUB, 6'd0, 5'd0, 32'd4, 32'd1, 1'b0));
    drive();
    @(negedge clk);
    check("rst_kills_rsp", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drain();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (rq[i].size() < 3 && $urandom_range(0, 2) != 0) rq[i].push_back(rand_op());
      step();
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < rq[i].size(); k++) rq[i][k].lock = 1'b0;
    if (lock_owner >= 0 && rq[lock_owner].size() == 0)
      rq[lock_owner].push_back(mk(OP_OR, 6'd0, 5'd0, 32'd1, 32'd2, 1'b0));
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
